wb_sram_slave: RTL and testbench

//  Wishbone B4 classic single-transfer responder (slave end of wb_bus_t) backing a

---
 rtl/wb_pkg.sv | 26 ++
 rtl/sram_1rw.sv | 50 +++++
 rtl/wb_sram_slave.sv | 146 ++++++++++++++
 tb/tb_wb_sram_slave.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, the slave FSM state type and the address
// decode helper used by the SRAM slave.
//   WB_ADDR_W / WB_DATA_W / WB_SEL_W : bus widths (byte address, data, lanes)
//   wb_slv_state_t                  : IDLE -> (WAIT) -> RESP -> IDLE
//   wb_adr_bad(off, aw)             : 1 when a base-relative byte offset is
//                                     misaligned or beyond 4*2**aw bytes
package wb_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_slv_state_t;

  // off is (adr - BASE_ADDR). An address below the base wraps to a huge
  // offset, so a single upper-bits test covers both range limits.
  function automatic logic wb_adr_bad(input logic [WB_ADDR_W-1:0] off,
                                      input int aw);
    return (off[1:0] != 2'b00) || ((off >> (aw + 2)) != '0);
  endfunction

endpackage

// File: rtl/sram_1rw.sv
// sram_1rw: single-port word SRAM with per-byte write enables and a
// registered read port.
//   clk      : clock
//   i_rst    : asynchronous active-high reset (clears the read register only)
//   i_en     : port enable; with i_we=0 a read, with i_we=1 a write
//   i_we     : write select
//   i_be     : byte-lane write enables (bit n -> data[8n+7:8n])
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : read data, updated only by reads, held otherwise
module sram_1rw
  import wb_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_we,
  input  logic [WB_SEL_W-1:0]      i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WB_DATA_W-1:0]     i_wdata,
  output logic [WB_DATA_W-1:0]     o_rdata
);

  // One byte-wide array per lane so each lane's write enable maps onto its
  // own RAM column without read-modify-write.
  genvar gi;
  for (gi = 0; gi < WB_SEL_W; gi++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    always_ff @(posedge clk) begin
      if (i_en && i_we && i_be[gi]) begin
        r_mem[i_addr] <= i_wdata[8*gi +: 8];
      end
    end

    always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
        r_q <= '0;
      end else if (i_en && !i_we) begin
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[8*gi +: 8] = r_q;
  end

endmodule

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B4 classic single-transfer slave in front of an
// on-chip SRAM, with programmable wait states, byte-lane writes and an error
// response for misaligned or out-of-window addresses.
//   clk, rst_i           : clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i   : cycle / strobe; a request is cyc & stb seen in IDLE
//   wb_we_i, wb_sel_i    : write flag, byte-lane enables
//   wb_adr_i, wb_dat_i   : byte address, write data
//   wb_dat_o             : read data (registered, holds last read)
//   wb_ack_o, wb_err_o   : one-cycle completion pulses, mutually exclusive
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int                   DEPTH       = 1024,
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0,
  parameter int                   WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic [WB_ADDR_W-1:0] wb_adr_i,
  input  logic [WB_DATA_W-1:0] wb_dat_i,
  output logic [WB_DATA_W-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o
);

  localparam int AW = $clog2(DEPTH);

  wb_slv_state_t        r_state;
  wb_slv_state_t        w_state_next;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;

  logic [WB_ADDR_W-1:0] r_adr;
  logic                 r_we;
  logic [WB_SEL_W-1:0]  r_sel;
  logic [WB_DATA_W-1:0] r_dat;

  logic                 w_req;
  logic                 w_in_idle;
  logic [WB_ADDR_W-1:0] w_adr_eff;
  logic [WB_ADDR_W-1:0] w_off_eff;
  logic                 w_we_eff;
  logic                 w_bad_eff;
  logic                 w_resp_live;
  logic                 w_mem_rd;
  logic                 w_mem_wr;

  assign w_req     = wb_cyc_i & wb_stb_i;
  assign w_in_idle = (r_state == IDLE);

  // With zero wait states the SRAM read has to be issued on the same edge
  // that captures the request, so in IDLE the decode looks at the live bus;
  // in WAIT/RESP it looks at the captured copy.
  assign w_adr_eff = w_in_idle ? wb_adr_i : r_adr;
  assign w_we_eff  = w_in_idle ? wb_we_i  : r_we;
  assign w_off_eff = w_adr_eff - BASE_ADDR;
  assign w_bad_eff = wb_adr_bad(w_off_eff, AW);

  // Dropping cyc during RESP aborts: no pulse and no write commit.
  assign w_resp_live = (r_state == RESP) & wb_cyc_i;
  assign wb_ack_o    = w_resp_live & ~w_bad_eff;
  assign wb_err_o    = w_resp_live &  w_bad_eff;

  assign w_mem_rd = (w_state_next == RESP) & ~w_we_eff & ~w_bad_eff;
  assign w_mem_wr = w_resp_live & r_we & ~w_bad_eff;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = 4'd1;
          end
        end
      end
      WAIT: begin
        // stb is deliberately ignored here; only cyc can cancel.
        if (!wb_cyc_i) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == 4'(WAIT_STATES)) begin
          w_state_next = RESP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      RESP: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_adr <= '0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_dat <= '0;
    end else if (w_in_idle && w_req) begin
      r_adr <= wb_adr_i;
      r_we  <= wb_we_i;
      r_sel <= wb_sel_i;
      r_dat <= wb_dat_i;
    end
  end

  sram_1rw #(
    .DEPTH(DEPTH)
  ) u_sram (
    .clk     (clk),
    .i_rst   (rst_i),
    .i_en    (w_mem_rd | w_mem_wr),
    .i_we    (w_mem_wr),
    .i_be    (r_sel),
    .i_addr  (w_off_eff[AW+1:2]),
    .i_wdata (r_dat),
    .o_rdata (wb_dat_o)
  );

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed bench for wb_sram_slave. Three instances share
// the bus inputs and clock/reset but each has its own cyc, so only the
// selected one responds:
//   d=0: DEPTH 1024, BASE 0x0,         WAIT_STATES 0
//   d=1: DEPTH 1024, BASE 0x0,         WAIT_STATES 3
//   d=2: DEPTH 256,  BASE 0x4000_0000, WAIT_STATES 5
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cyc_v = 3'b000;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;

  logic        ack0, ack1, ack2, err0, err1, err2;
  logic [31:0] dat0, dat1, dat2;
  logic [2:0]  ack_v, err_v;
  logic [31:0] dat_v [3];

  int checks = 0;
  int failures = 0;

  assign ack_v = {ack2, ack1, ack0};
  assign err_v = {err2, err1, err0};
  assign dat_v[0] = dat0;
  assign dat_v[1] = dat1;
  assign dat_v[2] = dat2;

  always #5 clk = ~clk;

  wb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_i(rst), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat0), .wb_ack_o(ack0), .wb_err_o(err0));

  wb_sram_slave #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_i(rst), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat1), .wb_ack_o(ack1), .wb_err_o(err1));

  wb_sram_slave #(.DEPTH(256), .BASE_ADDR(32'h4000_0000), .WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst_i(rst), .wb_cyc_i(cyc_v[2]), .wb_stb_i(stb), .wb_we_i(we),
    .wb_sel_i(sel), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat2), .wb_ack_o(ack2), .wb_err_o(err2));

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? 32'h4000_0000 : 32'h0;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  function automatic logic [31:0] span_of(input int d);
    return (d == 2) ? 32'h400 : 32'h1000;
  endfunction

  task automatic drive_req(input int d, input logic i_we, input logic [3:0] i_sel,
                           input logic [31:0] i_adr, input logic [31:0] i_dat);
    cyc_v = 3'b000;
    cyc_v[d] = 1'b1;
    stb = 1'b1;
    we = i_we;
    sel = i_sel;
    adr = i_adr;
    wdat = i_dat;
  endtask

  task automatic drop_req();
    cyc_v = 3'b000;
    stb = 1'b0;
  endtask

  // One complete transfer; o_lat counts rising edges from request to the
  // response pulse (0 = no response within the bound).
  task automatic xfer(input int d, input logic i_we, input logic [3:0] i_sel,
                      input logic [31:0] i_adr, input logic [31:0] i_dat,
                      output logic o_ack, output logic o_err,
                      output logic [31:0] o_dat, output int o_lat);
    o_ack = 1'b0;
    o_err = 1'b0;
    o_dat = 32'h0;
    o_lat = 0;
    @(posedge clk); #1;
    drive_req(d, i_we, i_sel, i_adr, i_dat);
    for (int i = 1; i <= 40 && o_lat == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_v[d] || err_v[d]) begin
        o_ack = ack_v[d];
        o_err = err_v[d];
        o_dat = dat_v[d];
        o_lat = i;
      end
    end
    @(posedge clk); #1;
    drop_req();
    $display("xfer d=%0d we=%0b sel=%h adr=%h wdat=%h ack=%0b err=%0b lat=%0d rdat=%h",
             d, i_we, i_sel, i_adr, i_dat, o_ack, o_err, o_lat, o_dat);
  endtask

  task automatic test_reset();
    drop_req();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ack_v[d] !== 1'b0 || err_v[d] !== 1'b0 || dat_v[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs d=%0d got ack=%0b err=%0b dat=%h want 0 0 00000000",
                 d, ack_v[d], err_v[d], dat_v[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read(input int d);
    logic a, e;
    logic [31:0] r;
    int l;
    xfer(d, 1'b1, 4'hF, base_of(d) + 32'h10, 32'hDEAD_BEEF, a, e, r, l);
    checks++;
    if (a !== 1'b1 || e !== 1'b0) begin
      failures++;
      $display("FAIL wr_resp d=%0d got ack=%0b err=%0b want 1 0", d, a, e);
    end
    checks++;
    if (l !== 1 + ws_of(d)) begin
      failures++;
      $display("FAIL wr_latency d=%0d got %0d want %0d", d, l, 1 + ws_of(d));
    end
    xfer(d, 1'b0, 4'hF, base_of(d) + 32'h10, 32'h0, a, e, r, l);
    checks++;
    if (a !== 1'b1 || l !== 1 + ws_of(d)) begin
      failures++;
      $display("FAIL rd_resp d=%0d got ack=%0b lat=%0d want 1 %0d", d, a, l, 1 + ws_of(d));
    end
    checks++;
    if (r !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_data d=%0d got %h want deadbeef", d, r);
    end
  endtask

  task automatic test_byte_lanes();
    logic        t_we  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0]  t_sel [8] = '{4'hF, 4'hF, 4'h1, 4'hF, 4'h3, 4'hF, 4'h0, 4'h1};
    logic [31:0] t_adr [8] = '{32'h20, 32'h24, 32'h24, 32'h24, 32'h24, 32'h24, 32'h20, 32'h20};
    logic [31:0] t_dat [8] = '{32'h1122_3344, 32'h0, 32'hAABB_CCDD, 32'h0,
                               32'hAABB_CCDD, 32'h0, 32'hAABB_CCDD, 32'h0};
    logic [31:0] t_exp [8] = '{32'h0, 32'h0, 32'h0, 32'h0000_00DD,
                               32'h0, 32'h0000_CCDD, 32'h0, 32'h1122_3344};
    logic a, e;
    logic [31:0] r;
    int l;
    for (int k = 0; k < 8; k++) begin
      xfer(0, t_we[k], t_sel[k], t_adr[k], t_dat[k], a, e, r, l);
      checks++;
      if (a !== 1'b1 || e !== 1'b0) begin
        failures++;
        $display("FAIL lane_resp step=%0d got ack=%0b err=%0b want 1 0", k, a, e);
      end
      if (!t_we[k]) begin
        checks++;
        if (r !== t_exp[k]) begin
          failures++;
          $display("FAIL lane_data step=%0d got %h want %h", k, r, t_exp[k]);
        end
      end
    end
  endtask

  // stb held high across the ack: a second read must start after one idle cycle.
  task automatic test_back_to_back(input int d);
    int first, second;
    first = 0;
    second = 0;
    @(posedge clk); #1;
    drive_req(d, 1'b0, 4'hF, base_of(d) + 32'h10, 32'h0);
    for (int i = 1; i <= 60 && second == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_v[d] === 1'b1) begin
        if (first == 0) first = i;
        else second = i;
      end
    end
    @(posedge clk); #1;
    drop_req();
    $display("b2b d=%0d first_ack=%0d second_ack=%0d dat=%h", d, first, second, dat_v[d]);
    checks++;
    if (first !== 1 + ws_of(d)) begin
      failures++;
      $display("FAIL b2b_first d=%0d got %0d want %0d", d, first, 1 + ws_of(d));
    end
    checks++;
    if (second - first !== 2 + ws_of(d)) begin
      failures++;
      $display("FAIL b2b_gap d=%0d got %0d want %0d", d, second - first, 2 + ws_of(d));
    end
    checks++;
    if (dat_v[d] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL b2b_data d=%0d got %h want deadbeef", d, dat_v[d]);
    end
  endtask

  task automatic test_errors(input int d);
    logic [31:0] bad_adr [3];
    logic        bad_we  [3] = '{1'b1, 1'b1, 1'b0};
    logic a, e;
    logic [31:0] r;
    int l;
    bad_adr[0] = base_of(d) + 32'h13;
    bad_adr[1] = base_of(d) + span_of(d);
    bad_adr[2] = base_of(d) - 32'h4;
    xfer(d, 1'b1, 4'hF, base_of(d), 32'h0000_A5A5, a, e, r, l);
    xfer(d, 1'b0, 4'hF, base_of(d) + 32'h10, 32'h0, a, e, r, l);
    for (int k = 0; k < 3; k++) begin
      xfer(d, bad_we[k], 4'hF, bad_adr[k], 32'h5555_5555, a, e, r, l);
      checks++;
      if (e !== 1'b1 || a !== 1'b0) begin
        failures++;
        $display("FAIL err_resp d=%0d adr=%h got ack=%0b err=%0b want 0 1", d, bad_adr[k], a, e);
      end
      checks++;
      if (l !== 1 + ws_of(d)) begin
        failures++;
        $display("FAIL err_latency d=%0d adr=%h got %0d want %0d", d, bad_adr[k], l, 1 + ws_of(d));
      end
      checks++;
      if (r !== 32'hDEAD_BEEF) begin
        failures++;
        $display("FAIL err_dat_hold d=%0d adr=%h got %h want deadbeef", d, bad_adr[k], r);
      end
    end
    xfer(d, 1'b0, 4'hF, base_of(d), 32'h0, a, e, r, l);
    checks++;
    if (r !== 32'h0000_A5A5) begin
      failures++;
      $display("FAIL err_mem_word0 d=%0d got %h want 0000a5a5", d, r);
    end
    xfer(d, 1'b0, 4'hF, base_of(d) + 32'h10, 32'h0, a, e, r, l);
    checks++;
    if (r !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL err_mem_word4 d=%0d got %h want deadbeef", d, r);
    end
  endtask

  task automatic test_abort();
    logic a, e;
    logic [31:0] r;
    int l;
    logic seen;
    xfer(2, 1'b1, 4'hF, base_of(2) + 32'h50, 32'h0102_0304, a, e, r, l);
    @(posedge clk); #1;
    drive_req(2, 1'b1, 4'hF, base_of(2) + 32'h50, 32'hCAFE_F00D);
    repeat (3) @(posedge clk);
    #1;
    drop_req();
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack_v[2] !== 1'b0 || err_v[2] !== 1'b0) seen = 1'b1;
    end
    $display("abort d=2 response_seen=%0b", seen);
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_pulse got response_seen=%0b want 0", seen);
    end
    xfer(2, 1'b0, 4'hF, base_of(2) + 32'h50, 32'h0, a, e, r, l);
    checks++;
    if (r !== 32'h0102_0304) begin
      failures++;
      $display("FAIL abort_mem got %h want 01020304", r);
    end
  endtask

  // stb dropped for two cycles while waiting must not disturb the transfer.
  task automatic test_stb_drop();
    logic a, e;
    logic [31:0] r;
    int l;
    int lat;
    lat = 0;
    @(posedge clk); #1;
    drive_req(2, 1'b1, 4'hF, base_of(2) + 32'h60, 32'h0BAD_F00D);
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(posedge clk);
      if (i == 1) begin #1; stb = 1'b0; end
      if (i == 3) begin #1; stb = 1'b1; end
      @(negedge clk);
      if (ack_v[2] === 1'b1) lat = i;
    end
    @(posedge clk); #1;
    drop_req();
    $display("stb_drop d=2 ack_lat=%0d", lat);
    checks++;
    if (lat !== 6) begin
      failures++;
      $display("FAIL stb_drop_latency got %0d want 6", lat);
    end
    xfer(2, 1'b0, 4'hF, base_of(2) + 32'h60, 32'h0, a, e, r, l);
    checks++;
    if (r !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL stb_drop_data got %h want 0badf00d", r);
    end
  endtask

  // Reset asserted mid-WAIT (phase 0) and during the RESP cycle (phase 1).
  task automatic test_reset_mid();
    logic [31:0] old_v [2] = '{32'h1234_5678, 32'h9ABC_DEF0};
    logic a, e;
    logic [31:0] r;
    int l;
    for (int ph = 0; ph < 2; ph++) begin
      xfer(1, 1'b1, 4'hF, 32'h30 + 32'(4 * ph), old_v[ph], a, e, r, l);
      @(posedge clk); #1;
      drive_req(1, 1'b1, 4'hF, 32'h30 + 32'(4 * ph), 32'hFFFF_FFFF);
      repeat ((ph == 0) ? 2 : 4) @(posedge clk);
      if (ph == 1) begin
        @(negedge clk);
        checks++;
        if (ack_v[1] !== 1'b1) begin
          failures++;
          $display("FAIL rst_pre_ack got %0b want 1", ack_v[1]);
        end
      end
      #1;
      rst = 1'b1;
      #1;
      $display("reset_mid phase=%0d ack=%0b err=%0b dat=%h", ph, ack_v[1], err_v[1], dat_v[1]);
      checks++;
      if (ack_v[1] !== 1'b0 || err_v[1] !== 1'b0 || dat_v[1] !== 32'h0) begin
        failures++;
        $display("FAIL rst_async phase=%0d got ack=%0b err=%0b dat=%h want 0 0 00000000",
                 ph, ack_v[1], err_v[1], dat_v[1]);
      end
      drop_req();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      xfer(1, 1'b0, 4'hF, 32'h30 + 32'(4 * ph), 32'h0, a, e, r, l);
      checks++;
      if (r !== old_v[ph] || l !== 4) begin
        failures++;
        $display("FAIL rst_no_write phase=%0d got dat=%h lat=%0d want %h 4", ph, r, l, old_v[ph]);
      end
    end
  endtask

  initial begin
    test_reset();
    for (int d = 0; d < 3; d++) test_write_read(d);
    test_byte_lanes();
    test_back_to_back(0);
    test_back_to_back(2);
    test_errors(0);
    test_errors(2);
    test_abort();
    test_stb_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
